// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM target port between VGA refill (m0, priority),
// imem (m1) and dmem (m2). Grants are combinational with no added latency, and
// read returns are steered back to their issuer through an in-order tag FIFO.
module sram_arbiter #(
  parameter int unsigned AW          = 18,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned BURST_LIMIT = 8
) (
  input  logic          clk25MHz,
  input  logic          reset_n,
  // master 0: VGA refill
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_rd,
  input  logic          m0_wr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_wait,
  output logic [31:0]   m0_rdata,
  output logic          m0_rvalid,
  // master 1: imem
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_rd,
  input  logic          m1_wr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_wait,
  output logic [31:0]   m1_rdata,
  output logic          m1_rvalid,
  // master 2: dmem
  input  logic [AW-1:0] m2_addr,
  input  logic          m2_rd,
  input  logic          m2_wr,
  input  logic [31:0]   m2_wdata,
  input  logic [3:0]    m2_be,
  output logic          m2_wait,
  output logic [31:0]   m2_rdata,
  output logic          m2_rvalid,
  // target: sram_ctrl
  output logic [AW-1:0] t_addr,
  output logic          t_rd,
  output logic          t_wr,
  output logic [31:0]   t_wdata,
  output logic [3:0]    t_be,
  input  logic          t_wait,
  input  logic [31:0]   t_rdata,
  input  logic          t_rvalid,
  output logic          err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(BURST_LIMIT + 1);

  typedef enum logic [1:0] {
    GNT_M0   = 2'd0,
    GNT_M1   = 2'd1,
    GNT_M2   = 2'd2,
    GNT_NONE = 2'd3
  } gnt_e;

  logic [1:0]    tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [BW-1:0] burst_cnt;
  logic          rr_ptr;          // 0: m1 first, 1: m2 first

  gnt_e          gnt;
  logic [2:0]    elig;
  logic          fifo_full, sel_rd, sel_wr, accept, push, pop;
  logic [1:0]    head;

  assign fifo_full = (count == CW'(DEPTH));
  assign elig[0]   = (m0_rd | m0_wr) & ~(m0_rd & fifo_full);
  assign elig[1]   = (m1_rd | m1_wr) & ~(m1_rd & fifo_full);
  assign elig[2]   = (m2_rd | m2_wr) & ~(m2_rd & fifo_full);

  // Grant selection: m0 first until its burst budget runs out, then round-robin m1/m2
  always_comb begin
    gnt = GNT_NONE;
    if (reset_n) begin
      if (elig[0] && ((burst_cnt < BW'(BURST_LIMIT)) || !(elig[1] || elig[2]))) begin
        gnt = GNT_M0;
      end else if (!rr_ptr) begin
        if (elig[1])      gnt = GNT_M1;
        else if (elig[2]) gnt = GNT_M2;
      end else begin
        if (elig[2])      gnt = GNT_M2;
        else if (elig[1]) gnt = GNT_M1;
      end
    end
  end

  // Target-side mux of the granted master's request fields
  always_comb begin
    t_addr  = '0;
    t_wdata = '0;
    t_be    = '0;
    sel_rd  = 1'b0;
    sel_wr  = 1'b0;
    case (gnt)
      GNT_M0: begin
        t_addr = m0_addr; t_wdata = m0_wdata; t_be = m0_be; sel_rd = m0_rd; sel_wr = m0_wr;
      end
      GNT_M1: begin
        t_addr = m1_addr; t_wdata = m1_wdata; t_be = m1_be; sel_rd = m1_rd; sel_wr = m1_wr;
      end
      GNT_M2: begin
        t_addr = m2_addr; t_wdata = m2_wdata; t_be = m2_be; sel_rd = m2_rd; sel_wr = m2_wr;
      end
      default: ;
    endcase
  end

  assign t_rd   = sel_rd;
  assign t_wr   = sel_wr;
  assign accept = (gnt != GNT_NONE) & ~t_wait;
  assign push   = accept & sel_rd;
  assign pop    = t_rvalid & (count != '0);
  assign head   = tag_mem[rd_ptr];

  assign m0_wait = (m0_rd | m0_wr) & ~(accept & (gnt == GNT_M0));
  assign m1_wait = (m1_rd | m1_wr) & ~(accept & (gnt == GNT_M1));
  assign m2_wait = (m2_rd | m2_wr) & ~(accept & (gnt == GNT_M2));

  assign m0_rdata  = t_rdata;
  assign m1_rdata  = t_rdata;
  assign m2_rdata  = t_rdata;
  assign m0_rvalid = reset_n & pop & (head == 2'd0);
  assign m1_rvalid = reset_n & pop & (head == 2'd1);
  assign m2_rvalid = reset_n & pop & (head == 2'd2);

  // Tag storage; contents are meaningless while count is zero so no reset needed
  always_ff @(posedge clk25MHz) begin
    if (reset_n && push) tag_mem[wr_ptr] <= 2'(gnt);
  end

  // FIFO pointers, burst budget, round-robin pointer and sticky error
  always_ff @(posedge clk25MHz) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (t_rvalid && (count == '0)) err <= 1'b1;

      if (accept && (gnt != GNT_M0)) begin
        burst_cnt <= '0;
      end else if (accept) begin
        if (burst_cnt < BW'(BURST_LIMIT)) burst_cnt <= burst_cnt + BW'(1);
      end else if (!(m0_rd | m0_wr)) begin
        burst_cnt <= '0;
      end

      if (accept && (gnt == GNT_M1)) rr_ptr <= 1'b1;
      if (accept && (gnt == GNT_M2)) rr_ptr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs change just after the falling edge,
// outputs are checked 1 ns later, state advances on the rising edge.
module tb_sram_arbiter;

  localparam int unsigned AW = 18;

  logic          clk25MHz = 1'b0;
  logic          reset_n  = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, m2_addr = '0;
  logic          m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0, m2_rd = 1'b0, m2_wr = 1'b0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0, m2_wdata = '0;
  logic [3:0]    m0_be = '0, m1_be = '0, m2_be = '0;
  logic          m0_wait, m1_wait, m2_wait;
  logic [31:0]   m0_rdata, m1_rdata, m2_rdata;
  logic          m0_rvalid, m1_rvalid, m2_rvalid;
  logic [AW-1:0] t_addr;
  logic          t_rd, t_wr;
  logic [31:0]   t_wdata;
  logic [3:0]    t_be;
  logic          t_wait = 1'b0;
  logic [31:0]   t_rdata = '0;
  logic          t_rvalid = 1'b0;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  always #20 clk25MHz = ~clk25MHz;

  sram_arbiter #(.AW(AW), .DEPTH(4), .BURST_LIMIT(8)) dut (
    .clk25MHz (clk25MHz), .reset_n (reset_n),
    .m0_addr (m0_addr), .m0_rd (m0_rd), .m0_wr (m0_wr), .m0_wdata (m0_wdata), .m0_be (m0_be),
    .m0_wait (m0_wait), .m0_rdata (m0_rdata), .m0_rvalid (m0_rvalid),
    .m1_addr (m1_addr), .m1_rd (m1_rd), .m1_wr (m1_wr), .m1_wdata (m1_wdata), .m1_be (m1_be),
    .m1_wait (m1_wait), .m1_rdata (m1_rdata), .m1_rvalid (m1_rvalid),
    .m2_addr (m2_addr), .m2_rd (m2_rd), .m2_wr (m2_wr), .m2_wdata (m2_wdata), .m2_be (m2_be),
    .m2_wait (m2_wait), .m2_rdata (m2_rdata), .m2_rvalid (m2_rvalid),
    .t_addr (t_addr), .t_rd (t_rd), .t_wr (t_wr), .t_wdata (t_wdata), .t_be (t_be),
    .t_wait (t_wait), .t_rdata (t_rdata), .t_rvalid (t_rvalid), .err (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk25MHz);
  endtask

  initial begin
    // Reset: requests must see wait, target strobes stay low
    nxt(); reset_n = 1'b0; m1_rd = 1'b1; #1;
    chk("rst_m1_wait", 32'(m1_wait), 1);
    chk("rst_t_rd", 32'(t_rd), 0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
    nxt(); m1_rd = 1'b0;
    nxt(); reset_n = 1'b1; #1;
    chk("idle_err", 32'(err), 0);
    chk("idle_t_rd", 32'(t_rd), 0);
    chk("idle_t_wr", 32'(t_wr), 0);

    // m1 and m2 reads, m0 idle: alternate m1,m2,m1,m2 then FIFO full
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (i == 0) begin
        m1_rd = 1'b1; m1_addr = 18'h00111;
        m2_rd = 1'b1; m2_addr = 18'h00222;
      end
      #1;
      chk("rr_t_rd", 32'(t_rd), 1);
      chk("rr_t_addr", 32'(t_addr), (i % 2 == 0) ? 32'h111 : 32'h222);
      chk("rr_m1_wait", 32'(m1_wait), (i % 2 == 0) ? 0 : 1);
      chk("rr_m2_wait", 32'(m2_wait), (i % 2 == 0) ? 1 : 0);
    end
    nxt(); #1;
    chk("rr_full_t_rd", 32'(t_rd), 0);
    chk("rr_full_m1_wait", 32'(m1_wait), 1);
    chk("rr_full_m2_wait", 32'(m2_wait), 1);
    // Returns come back in issue order: m1,m2,m1,m2
    for (int i = 0; i < 4; i++) begin
      nxt();
      m1_rd = 1'b0; m2_rd = 1'b0;
      t_rvalid = 1'b1; t_rdata = 32'hA000_0000 + 32'(i);
      #1;
      chk("rr_ret_m1_rvalid", 32'(m1_rvalid), (i % 2 == 0) ? 1 : 0);
      chk("rr_ret_m2_rvalid", 32'(m2_rvalid), (i % 2 == 0) ? 0 : 1);
      chk("rr_ret_m0_rvalid", 32'(m0_rvalid), 0);
      chk("rr_ret_rdata", (i % 2 == 0) ? m1_rdata : m2_rdata, 32'hA000_0000 + 32'(i));
    end
    nxt(); t_rvalid = 1'b0; #1;
    chk("rr_err", 32'(err), 0);

    // Single m1 read at 0x100, data two cycles later
    nxt(); m1_rd = 1'b1; m1_addr = 18'h00100; #1;
    chk("t1_t_rd", 32'(t_rd), 1);
    chk("t1_t_addr", 32'(t_addr), 32'h100);
    chk("t1_m1_wait", 32'(m1_wait), 0);
    nxt(); m1_rd = 1'b0; #1;
    chk("t1_t_rd_off", 32'(t_rd), 0);
    nxt(); t_rvalid = 1'b1; t_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_m1_rvalid", 32'(m1_rvalid), 1);
    chk("t1_m0_rvalid", 32'(m0_rvalid), 0);
    chk("t1_m2_rvalid", 32'(m2_rvalid), 0);
    chk("t1_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    nxt(); t_rvalid = 1'b0;

    // FIFO full: 5th read waits, m2 write still accepted, one return frees a slot
    for (int i = 0; i < 4; i++) begin
      nxt();
      if (i == 0) begin m1_rd = 1'b1; m1_addr = 18'h30000; end
      #1;
      chk("t4_m1_wait", 32'(m1_wait), 0);
      chk("t4_t_rd", 32'(t_rd), 1);
    end
    nxt(); #1;
    chk("t4_5th_wait", 32'(m1_wait), 1);
    chk("t4_5th_t_rd", 32'(t_rd), 0);
    nxt(); m2_wr = 1'b1; m2_addr = 18'h2AAAA; m2_wdata = 32'h1234_5678; m2_be = 4'hF; #1;
    chk("t4_wr_t_wr", 32'(t_wr), 1);
    chk("t4_wr_t_addr", 32'(t_addr), 32'h2AAAA);
    chk("t4_wr_t_wdata", t_wdata, 32'h1234_5678);
    chk("t4_wr_m2_wait", 32'(m2_wait), 0);
    chk("t4_wr_m1_wait", 32'(m1_wait), 1);
    nxt(); m2_wr = 1'b0; t_rvalid = 1'b1; #1;
    chk("t4_pop_m1_rvalid", 32'(m1_rvalid), 1);
    chk("t4_pop_m1_wait", 32'(m1_wait), 1);
    nxt(); t_rvalid = 1'b0; #1;
    chk("t4_freed_m1_wait", 32'(m1_wait), 0);
    chk("t4_freed_t_rd", 32'(t_rd), 1);
    nxt(); m1_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt(); t_rvalid = 1'b1; #1;
      chk("t4_drain_m1_rvalid", 32'(m1_rvalid), 1);
    end
    nxt(); t_rvalid = 1'b0; #1;
    chk("t4_err", 32'(err), 0);

    // m0 streams writes while m2 read pends: 8 m0 grants, then m2, then m0
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (i == 0) begin
        m0_wr = 1'b1; m0_addr = 18'h00ABC; m0_wdata = 32'h5555_AAAA; m0_be = 4'hF;
        m2_rd = 1'b1; m2_addr = 18'h12345;
      end
      #1;
      chk("t2_m0_t_wr", 32'(t_wr), 1);
      chk("t2_m0_t_addr", 32'(t_addr), 32'h00ABC);
      chk("t2_m0_wait", 32'(m0_wait), 0);
      chk("t2_m2_wait", 32'(m2_wait), 1);
    end
    nxt(); #1;
    chk("t2_c9_t_rd", 32'(t_rd), 1);
    chk("t2_c9_t_wr", 32'(t_wr), 0);
    chk("t2_c9_t_addr", 32'(t_addr), 32'h12345);
    chk("t2_c9_m2_wait", 32'(m2_wait), 0);
    chk("t2_c9_m0_wait", 32'(m0_wait), 1);
    nxt(); m2_rd = 1'b0; #1;
    chk("t2_c10_t_wr", 32'(t_wr), 1);
    chk("t2_c10_m0_wait", 32'(m0_wait), 0);
    nxt(); m0_wr = 1'b0; t_rvalid = 1'b1; t_rdata = 32'h0BAD_F00D; #1;
    chk("t2_m2_rvalid", 32'(m2_rvalid), 1);
    chk("t2_m0_rvalid", 32'(m0_rvalid), 0);
    nxt(); t_rvalid = 1'b0;

    // Target stall on an m1 write: held 3 cycles, accepted on the 4th
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (i == 0) begin
        m1_wr = 1'b1; m1_addr = 18'h00555; m1_wdata = 32'hCAFE_F00D; m1_be = 4'h5;
        t_wait = 1'b1;
      end
      #1;
      chk("t5_stall_t_wr", 32'(t_wr), 1);
      chk("t5_stall_m1_wait", 32'(m1_wait), 1);
      chk("t5_stall_t_wdata", t_wdata, 32'hCAFE_F00D);
      chk("t5_stall_t_be", 32'(t_be), 32'h5);
    end
    nxt(); t_wait = 1'b0; #1;
    chk("t5_acc_m1_wait", 32'(m1_wait), 0);
    chk("t5_acc_t_wr", 32'(t_wr), 1);
    nxt(); m1_wr = 1'b0; #1;
    chk("t5_idle_t_wr", 32'(t_wr), 0);

    // Reset with 2 reads outstanding: late return flags err, no rvalid
    nxt(); m1_rd = 1'b1; m1_addr = 18'h00042; #1;
    chk("t6_rd0_m1_wait", 32'(m1_wait), 0);
    nxt(); #1;
    chk("t6_rd1_m1_wait", 32'(m1_wait), 0);
    nxt(); m1_rd = 1'b0; reset_n = 1'b0; #1;
    chk("t6_rst_t_rd", 32'(t_rd), 0);
    nxt(); reset_n = 1'b1; t_rvalid = 1'b1; t_rdata = 32'h7777_7777; #1;
    chk("t6_m1_rvalid", 32'(m1_rvalid), 0);
    chk("t6_m0_rvalid", 32'(m0_rvalid), 0);
    chk("t6_m2_rvalid", 32'(m2_rvalid), 0);
    nxt(); t_rvalid = 1'b0; #1;
    chk("t6_err_set", 32'(err), 1);
    nxt(); nxt(); #1;
    chk("t6_err_sticky", 32'(err), 1);
    nxt(); reset_n = 1'b0;
    nxt(); reset_n = 1'b1; #1;
    chk("t6_err_cleared", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
